// File: rtl/cp0_v2.sv
// cp0_v2 - MIPS32 coprocessor-0 register file, second generation.
// Holds BadVAddr, Count, Compare, Status, Cause, EPC and Config. Count
// advances once every COUNT_DIV clocks. The timer interrupt is armed by the
// first Compare write. Hardware interrupts are sampled through one register
// stage.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   we/waddr/wsel/wdata         MTC0 write port (nonzero wsel drops the write)
//   raddr/rsel -> rdata         MFC0 read port, combinational
//   exc_valid/exc_code/exc_eret/exc_bd/exc_pc/exc_badvaddr_we/exc_badvaddr
//                               commit-stage exception and ERET interface
//   hw_int_i                    level hardware interrupts
//   int_req_o, timer_int_o      masked interrupt request, Cause.TI
//   count_o .. badvaddr_o       register views
module cp0_v2 #(
  parameter int unsigned N_HW_INT     = 6,
  parameter int unsigned COUNT_DIV    = 2,
  parameter logic [31:0] CONFIG_VAL   = 32'h0000_0001,
  parameter logic [31:0] RESET_STATUS = 32'h0040_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [4:0]          waddr,
  input  logic [2:0]          wsel,
  input  logic [31:0]         wdata,
  input  logic [4:0]          raddr,
  input  logic [2:0]          rsel,
  output logic [31:0]         rdata,
  input  logic                exc_valid,
  input  logic [4:0]          exc_code,
  input  logic                exc_eret,
  input  logic                exc_bd,
  input  logic [31:0]         exc_pc,
  input  logic                exc_badvaddr_we,
  input  logic [31:0]         exc_badvaddr,
  input  logic [N_HW_INT-1:0] hw_int_i,
  output logic                int_req_o,
  output logic                timer_int_o,
  output logic [31:0]         count_o,
  output logic [31:0]         compare_o,
  output logic [31:0]         status_o,
  output logic [31:0]         cause_o,
  output logic [31:0]         epc_o,
  output logic [31:0]         badvaddr_o
);

  localparam int unsigned   PW          = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX   = PW'(COUNT_DIV - 1);
  localparam logic [31:0]   STATUS_MASK = 32'h0040_FF03;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_CONFIG   = 5'd16;

  logic [31:0]         count, compare, status, epc, badvaddr, cause;
  logic [PW-1:0]       presc;
  logic [N_HW_INT-1:0] hw_q;
  logic                armed, ti, cause_bd;
  logic [1:0]          ip_sw;
  logic [4:0]          exc_code_q;
  logic [5:0]          ip_hw;
  logic [7:0]          ip;

  // A committed exception or ERET flushes the instruction doing the MTC0.
  logic wr_en, wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  assign wr_en      = we && (wsel == '0) && !exc_valid && !exc_eret;
  assign wr_count   = wr_en && (waddr == REG_COUNT);
  assign wr_compare = wr_en && (waddr == REG_COMPARE);
  assign wr_status  = wr_en && (waddr == REG_STATUS);
  assign wr_cause   = wr_en && (waddr == REG_CAUSE);
  assign wr_epc     = wr_en && (waddr == REG_EPC);

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      compare    <= '0;
      status     <= RESET_STATUS;
      epc        <= '0;
      badvaddr   <= '0;
      presc      <= '0;
      hw_q       <= '0;
      armed      <= 1'b0;
      ti         <= 1'b0;
      cause_bd   <= 1'b0;
      ip_sw      <= '0;
      exc_code_q <= '0;
    end else begin
      hw_q <= hw_int_i;

      if (wr_count) begin
        count <= wdata;
        presc <= '0;
      end else if (presc == PRESC_MAX) begin
        presc <= '0;
        count <= count + 32'd1;
      end else begin
        presc <= presc + PW'(1);
      end

      // Compare write clears TI even when Count matches in the same cycle.
      if (wr_compare) begin
        compare <= wdata;
        armed   <= 1'b1;
        ti      <= 1'b0;
      end else if (armed && (count == compare)) begin
        ti <= 1'b1;
      end

      if (exc_valid) begin
        exc_code_q <= exc_code;
        if (!status[1]) begin
          epc      <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
          cause_bd <= exc_bd;
        end
        status[1] <= 1'b1;
        if (exc_badvaddr_we) badvaddr <= exc_badvaddr;
      end else if (exc_eret) begin
        status[1] <= 1'b0;
      end else begin
        if (wr_status) status <= wdata & STATUS_MASK;
        if (wr_cause)  ip_sw  <= wdata[9:8];
        if (wr_epc)    epc    <= wdata;
      end
    end
  end

  assign ip_hw = 6'(hw_q);
  assign ip    = {ip_hw[5] | ti, ip_hw[4:0], ip_sw};
  assign cause = {cause_bd, ti, 14'b0, ip, 1'b0, exc_code_q, 2'b0};

  always_comb begin
    rdata = '0;
    if (rsel == '0) begin
      case (raddr)
        REG_BADVADDR: rdata = badvaddr;
        REG_COUNT:    rdata = count;
        REG_COMPARE:  rdata = compare;
        REG_STATUS:   rdata = status;
        REG_CAUSE:    rdata = cause;
        REG_EPC:      rdata = epc;
        REG_CONFIG:   rdata = CONFIG_VAL;
        default:      rdata = '0;
      endcase
    end
  end

  assign int_req_o   = status[0] & ~status[1] & (|(status[15:8] & cause[15:8]));
  assign timer_int_o = ti;
  assign count_o     = count;
  assign compare_o   = compare;
  assign status_o    = status;
  assign cause_o     = cause;
  assign epc_o       = epc;
  assign badvaddr_o  = badvaddr;

endmodule

// File: tb/tb_cp0_v2.sv
// Bench for cp0_v2 at default parameters (COUNT_DIV=2, N_HW_INT=6).
module tb_cp0_v2;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr, raddr;
  logic [2:0]  wsel, rsel;
  logic [31:0] wdata, rdata;
  logic        exc_valid, exc_eret, exc_bd, exc_badvaddr_we;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc, exc_badvaddr;
  logic [5:0]  hw_int_i;
  logic        int_req_o, timer_int_o;
  logic [31:0] count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o;

  int total = 0;
  int bad   = 0;

  cp0_v2 #(
    .N_HW_INT(6),
    .COUNT_DIV(2),
    .CONFIG_VAL(32'h0000_0001),
    .RESET_STATUS(32'h0040_0000)
  ) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .raddr(raddr),
    .wsel(wsel), .rsel(rsel), .wdata(wdata), .rdata(rdata),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_eret(exc_eret),
    .exc_bd(exc_bd), .exc_pc(exc_pc), .exc_badvaddr_we(exc_badvaddr_we),
    .exc_badvaddr(exc_badvaddr), .hw_int_i(hw_int_i),
    .int_req_o(int_req_o), .timer_int_o(timer_int_o),
    .count_o(count_o), .compare_o(compare_o), .status_o(status_o),
    .cause_o(cause_o), .epc_o(epc_o), .badvaddr_o(badvaddr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [2:0]  wsel;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [2:0]  rsel;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wsel = 3'd0; wdata = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; we = 1'b0; waddr = '0; raddr = '0; wsel = '0; rsel = '0;
    wdata = '0; exc_valid = 1'b0; exc_eret = 1'b0; exc_bd = 1'b0;
    exc_code = '0; exc_pc = '0; exc_badvaddr_we = 1'b0; exc_badvaddr = '0;
    hw_int_i = '0;

    vecs[0]  = '{1'b1, 5'd12, 3'd0, 32'hFFFF_FFFF, 5'd12, 3'd0, 32'h0040_FF03};
    vecs[1]  = '{1'b1, 5'd13, 3'd0, 32'hFFFF_FFFF, 5'd13, 3'd0, 32'h0000_0300};
    vecs[2]  = '{1'b1, 5'd12, 3'd0, 32'h0000_0000, 5'd12, 3'd0, 32'h0000_0000};
    vecs[3]  = '{1'b1, 5'd13, 3'd0, 32'h0000_0000, 5'd13, 3'd0, 32'h0000_0000};
    vecs[4]  = '{1'b0, 5'd0,  3'd0, 32'h0000_0000, 5'd16, 3'd0, 32'h0000_0001};
    vecs[5]  = '{1'b0, 5'd0,  3'd0, 32'h0000_0000, 5'd16, 3'd1, 32'h0000_0000};
    vecs[6]  = '{1'b1, 5'd14, 3'd0, 32'h8000_0180, 5'd14, 3'd0, 32'h8000_0180};
    vecs[7]  = '{1'b1, 5'd14, 3'd1, 32'h0000_1234, 5'd14, 3'd0, 32'h8000_0180};
    vecs[8]  = '{1'b1, 5'd8,  3'd0, 32'hDEAD_BEEF, 5'd8,  3'd0, 32'h0000_0000};
    vecs[9]  = '{1'b1, 5'd5,  3'd0, 32'h5555_AAAA, 5'd5,  3'd0, 32'h0000_0000};
    vecs[10] = '{1'b1, 5'd14, 3'd0, 32'h0000_0044, 5'd14, 3'd2, 32'h0000_0000};

    // Reset state
    tick(); tick();
    check("rst_count", count_o, 32'h0);
    check("rst_compare", compare_o, 32'h0);
    check("rst_status", status_o, 32'h0040_0000);
    check("rst_cause", cause_o, 32'h0);
    check("rst_epc", epc_o, 32'h0);
    check("rst_badvaddr", badvaddr_o, 32'h0);
    check("rst_int_req", {31'b0, int_req_o}, 32'h0);
    check("rst_ti", {31'b0, timer_int_o}, 32'h0);

    // Prescaler
    rst = 1'b0;
    tick(); tick();
    check("presc_count_2clk", count_o, 32'd1);
    for (int i = 0; i < 8; i++) tick();
    check("presc_count_10clk", count_o, 32'd5);
    mtc0(5'd9, 32'hFFFF_FFFE);
    check("count_load", count_o, 32'hFFFF_FFFE);
    tick(); tick();
    check("count_ffff_ffff", count_o, 32'hFFFF_FFFF);
    tick(); tick();
    check("count_wrap", count_o, 32'h0);
    // Count==Compare==0 but timer unarmed
    tick(); tick();
    check("ti_unarmed", {31'b0, timer_int_o}, 32'h0);

    // Register masks and selects
    for (int i = 0; i < 11; i++) begin
      we = vecs[i].we; waddr = vecs[i].waddr; wsel = vecs[i].wsel;
      wdata = vecs[i].wdata; raddr = vecs[i].raddr; rsel = vecs[i].rsel;
      tick();
      we = 1'b0;
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp);
    end
    rsel = 3'd0;

    // Timer arming and stickiness
    mtc0(5'd9, 32'h0);
    mtc0(5'd11, 32'd8);
    check("compare_val", compare_o, 32'd8);
    n = 0;
    while (count_o != 32'd8 && n < 100) begin
      tick();
      n++;
    end
    check("timer_reach8", count_o, 32'd8);
    check("ti_not_yet", {31'b0, timer_int_o}, 32'h0);
    tick();
    check("ti_set", {31'b0, timer_int_o}, 32'h1);
    for (int i = 0; i < 20; i++) tick();
    check("ti_sticky", {31'b0, timer_int_o}, 32'h1);
    check("ti_cause_bits", cause_o & 32'h4000_8000, 32'h4000_8000);
    // Compare write in a match cycle clears TI; the next match sets it again
    mtc0(5'd9, 32'd20);
    mtc0(5'd11, 32'd20);
    check("ti_cleared_on_match_write", {31'b0, timer_int_o}, 32'h0);
    tick();
    check("ti_rematch", {31'b0, timer_int_o}, 32'h1);
    mtc0(5'd11, 32'h8000_0000);
    check("ti_cleared", {31'b0, timer_int_o}, 32'h0);

    // Interrupt masking
    mtc0(5'd12, 32'h0000_0401);
    hw_int_i = 6'b000001;
    check("int_req_pre", {31'b0, int_req_o}, 32'h0);
    tick();
    check("cause_ip2", cause_o & 32'h0000_FC00, 32'h0000_0400);
    check("int_req_on", {31'b0, int_req_o}, 32'h1);
    mtc0(5'd12, 32'h0000_0403);
    check("int_req_exl", {31'b0, int_req_o}, 32'h0);
    hw_int_i = 6'b100000;
    tick();
    check("cause_ip7_hw", cause_o & 32'h0000_FC00, 32'h0000_8000);
    hw_int_i = '0;
    mtc0(5'd12, 32'h0);

    // Exceptions
    exc_valid = 1'b1; exc_code = 5'd4; exc_bd = 1'b1; exc_pc = 32'hBFC0_0104;
    exc_badvaddr_we = 1'b1; exc_badvaddr = 32'h1234_5677;
    tick();
    exc_badvaddr_we = 1'b0;
    check("exc1_epc", epc_o, 32'hBFC0_0100);
    check("exc1_cause", cause_o & 32'h8000_007C, 32'h8000_0010);
    check("exc1_exl", status_o, 32'h0000_0002);
    check("exc1_badvaddr", badvaddr_o, 32'h1234_5677);
    exc_code = 5'd10; exc_bd = 1'b0; exc_pc = 32'h0000_1000;
    tick();
    exc_valid = 1'b0;
    check("exc2_epc", epc_o, 32'hBFC0_0100);
    check("exc2_cause", cause_o & 32'h8000_007C, 32'h8000_0028);

    // Priority: exception drops MTC0
    we = 1'b1; waddr = 5'd12; wdata = 32'h0; exc_valid = 1'b1; exc_code = 5'd0;
    tick();
    we = 1'b0; exc_valid = 1'b0;
    check("prio_mtc0_dropped", status_o, 32'h0000_0002);
    exc_eret = 1'b1;
    tick();
    exc_eret = 1'b0;
    check("eret_exl", status_o, 32'h0);
    exc_valid = 1'b1; exc_eret = 1'b1; exc_code = 5'd8; exc_pc = 32'h0000_2000;
    tick();
    exc_valid = 1'b0; exc_eret = 1'b0;
    check("prio_exc_over_eret", status_o, 32'h0000_0002);
    check("exc3_epc", epc_o, 32'h0000_2000);
    check("exc3_bd_clear", cause_o & 32'h8000_007C, 32'h0000_0020);

    // Reset overrides write and exception in the same cycle
    rst = 1'b1; we = 1'b1; waddr = 5'd14; wdata = 32'hFFFF_0000;
    exc_valid = 1'b1; exc_pc = 32'h0000_3000;
    tick();
    rst = 1'b0; we = 1'b0; exc_valid = 1'b0;
    check("midrst_status", status_o, 32'h0040_0000);
    check("midrst_epc", epc_o, 32'h0);
    check("midrst_cause", cause_o, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cp0_v2.md
# cp0_v2

Parametrised second-generation MIPS32 coprocessor-0 register file for the 5-stage core. It holds BadVAddr, Count, Compare, Status, Cause, EPC and Config. It adds a Count prescaler, a configurable hardware-interrupt width, registered interrupt sampling and an armed timer. It generates the masked interrupt request the pipeline converts into an exception. It is written by MTC0, read by MFC0, and updated by the commit-stage exception and ERET interface.

## Interface
- N_HW_INT, 6, number of hardware interrupt lines (1..6), mapped to Cause.IP[2+i]
- COUNT_DIV, 2, clock cycles per Count increment (1..16)
- CONFIG_VAL, 32'h0000_0001, constant read value of Config (reg 16, sel 0)
- RESET_STATUS, 32'h0040_0000, Status reset value (BEV=1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- we  in  1  MTC0 write strobe
- waddr, raddr  in  5  CP0 register number
- wsel, rsel  in  3  select; nonzero → write ignored, read returns 0
- wdata  in  32  MTC0 data
- rdata  out  32  MFC0 data, combinational from current register state
- exc_valid  in  1  committed exception this cycle
- exc_code  in  5  ExcCode (0 = interrupt)
- exc_eret  in  1  committed ERET this cycle
- exc_bd  in  1  excepting instruction is in a delay slot
- exc_pc  in  32  PC of excepting instruction
- exc_badvaddr_we  in  1  exception carries a faulting address
- exc_badvaddr  in  32  faulting address
- hw_int_i  in  N_HW_INT  level hardware interrupts, asynchronous to the pipeline
- int_req_o  out  1  masked, enabled interrupt pending
- timer_int_o  out  1  Cause.TI
- count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o  out  32  register views

## Operation
- Register numbers: BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14, Config 16. Any other number reads 0, and writes to it are dropped.
- Status write mask: BEV[22], IM[15:8], EXL[1], IE[0]. All other bits are forced to 0.
- Cause write mask: IP[9:8] (software interrupts) only.
- BadVAddr is read-only to MTC0. EPC, Count and Compare are fully writable.
- Prescaler (width clog2(COUNT_DIV), min 1) resets to 0.
  - Each cycle: if prescaler == COUNT_DIV-1, then prescaler←0 and Count←Count+1 (wraps FFFF_FFFF→0); otherwise prescaler++.
  - An MTC0 to Count loads wdata and clears the prescaler.
- Timer:
  - The `armed` flag resets to 0 and is set by any Compare write.
  - TI sets when armed && Count==Compare, except in a cycle with a Compare write.
  - A Compare write clears TI. It wins over a simultaneous match.
  - TI is sticky otherwise.
- Cause.IP[7:2]:
  - hw_int_i is registered one stage (hw_q) and reset to 0.
  - IP[2+i] = hw_q[i] for i<N_HW_INT. Unused bits are 0.
  - IP[7] is additionally ORed with TI.
- int_req_o = Status.IE & ~Status.EXL & |(Status.IM & Cause.IP[15:8]).
- Exception (exc_valid):
  - Cause.ExcCode ← exc_code.
  - If Status.EXL was 0: EPC ← exc_bd ? exc_pc-4 : exc_pc, and Cause.BD ← exc_bd. If EXL was 1, EPC and BD are held.
  - EXL ← 1.
  - If exc_badvaddr_we: BadVAddr ← exc_badvaddr.
- ERET (exc_eret, no exc_valid): EXL ← 0. If both are asserted, the exception wins and the ERET is ignored.
- Any exc_valid or exc_eret in a cycle discards that cycle's MTC0 entirely, because the pipeline flushes the instruction.
- Cause.BD, ExcCode and TI are never MTC0-writable.

## Timing
- Reset values:
  - Count, Compare, Cause, EPC, BadVAddr, prescaler, hw_q, armed: all 0.
  - Status = RESET_STATUS.
  - int_req_o = 0, timer_int_o = 0.
- All register updates are visible on outputs and rdata the cycle after the write, exception or ERET edge. There is no write-to-read bypass.
- hw_int_i to Cause.IP: 1 cycle. hw_int_i to int_req_o: 1 cycle, when enabled.
- TI is visible 1 cycle after the matching edge.
- Reset asserted mid-operation overrides all writes and exceptions in that cycle.

## Test plan
- Prescaler: COUNT_DIV=2, release reset → Count=1 after 2 clocks, 5 after 10. Then MTC0 Count=FFFF_FFFE → Count=FFFF_FFFF two clocks later, then 0 (wrap).
- Timer arming: no Compare write, Count passes 0 → TI stays 0. Write Compare=8 → TI=1 one cycle after Count==8, and it stays 1. Compare write in the same cycle as a match → TI=0.
- Interrupt masking: Status=0000_0401 (IM2, IE), hw_int_i[0]=1 → Cause.IP2=1 and int_req_o=1 after 1 cycle. Setting EXL=1 → int_req_o=0.
- Exception: EXL=0, exc_valid, exc_code=4, exc_bd=1, exc_pc=BFC0_0104, badvaddr_we=1, badvaddr=1234_5677 → EPC=BFC0_0100, BD=1, ExcCode=4, EXL=1, BadVAddr=1234_5677. A second exception with code 10 → ExcCode=10, EPC unchanged.
- Priority: MTC0 Status=0 together with exc_valid → Status keeps EXL=1 and the write is dropped. exc_valid together with exc_eret → EXL=1.
- Masks and selects:
  - MTC0 Cause=FFFF_FFFF → only IP[9:8] set.
  - MTC0 Status=FFFF_FFFF → Status reads 0040_FF03.
  - MFC0 reg 16 sel 0 → 0000_0001; reg 16 sel 1 → 0.
